// File: rtl/mmcm_lock_supervisor.sv
// MMCM lock supervisor: pulses MMCM_RST, waits for a stable synchronised LOCKED,
// retries failed locks a bounded number of times and releases downstream resets in stagger order.
module mmcm_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int NUM_OUT       = 2,
    parameter int STAGGER       = 8,
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic               CLKIN,
    input  logic               RSTN,
    input  logic               MMCM_LOCKED,
    input  logic               RELOCK_REQ,
    output logic               MMCM_RST,
    output logic [NUM_OUT-1:0] RST_OUT,
    output logic               READY,
    output logic               FAULT,
    output logic [RW-1:0]      RETRIES
);

    localparam int REL_SPAN = (NUM_OUT - 1) * STAGGER + 1;
    localparam int MAX_A    = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B    = (STABLE_CYCLES > REL_SPAN) ? STABLE_CYCLES : REL_SPAN;
    localparam int MAX_ALL  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW       = $clog2(MAX_ALL) + 1;

    localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that first sees lock counts as the first stable cycle.
    localparam logic [CW-1:0] SETTLE_LAST  = CW'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);
    localparam logic [CW-1:0] RELEASE_LAST = CW'((NUM_OUT - 1) * STAGGER);
    localparam logic [RW-1:0] MAX_R        = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_RELEASE,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [RW-1:0]      retries_q, retries_d;
    logic               sync_meta_q, lock_s_q;
    logic               mmcm_rst_q, mmcm_rst_d;
    logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;

    // Two-flop synchroniser for the asynchronous LOCKED pin.
    always_ff @(posedge CLKIN or negedge RSTN) begin
        if (!RSTN) begin
            sync_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            sync_meta_q <= MMCM_LOCKED;
            lock_s_q    <= sync_meta_q;
        end
    end

    // Next-state, counter and retry bookkeeping; RELOCK_REQ overrides everything.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retries_d = retries_q;
        if (RELOCK_REQ) begin
            state_d   = ST_HOLD;
            cnt_d     = {CW{1'b0}};
            retries_d = {RW{1'b0}};
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s_q) begin
                        cnt_d = {CW{1'b0}};
                        if (STABLE_CYCLES > 1) begin
                            state_d = ST_SETTLE;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d = {CW{1'b0}};
                        if (retries_q == MAX_R) begin
                            state_d = ST_FAULT;
                        end else begin
                            state_d   = ST_HOLD;
                            retries_d = retries_q + RW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (!lock_s_q) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = {CW{1'b0}};
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_RELEASE;
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (!lock_s_q) begin
                        state_d = ST_HOLD;
                        cnt_d   = {CW{1'b0}};
                    end else if (cnt_q == RELEASE_LAST) begin
                        state_d   = ST_RUN;
                        cnt_d     = {CW{1'b0}};
                        retries_d = {RW{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_RUN: begin
                    cnt_d = {CW{1'b0}};
                    if (!lock_s_q) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    cnt_d = {CW{1'b0}};
                end
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = {CW{1'b0}};
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        mmcm_rst_d = (state_d == ST_HOLD) || (state_d == ST_FAULT);
        ready_d    = (state_d == ST_RUN);
        fault_d    = (state_d == ST_FAULT);
        rst_out_d  = {NUM_OUT{1'b1}};
        for (int i = 0; i < NUM_OUT; i++) begin
            if (state_d == ST_RUN) begin
                rst_out_d[i] = 1'b0;
            end else if ((state_d == ST_RELEASE) && (cnt_d >= CW'(i * STAGGER))) begin
                rst_out_d[i] = 1'b0;
            end else begin
                rst_out_d[i] = 1'b1;
            end
        end
    end

    // FSM state, counter and registered outputs.
    always_ff @(posedge CLKIN or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= ST_HOLD;
            cnt_q      <= {CW{1'b0}};
            retries_q  <= {RW{1'b0}};
            mmcm_rst_q <= 1'b1;
            rst_out_q  <= {NUM_OUT{1'b1}};
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retries_q  <= retries_d;
            mmcm_rst_q <= mmcm_rst_d;
            rst_out_q  <= rst_out_d;
            ready_q    <= ready_d;
            fault_q    <= fault_d;
        end
    end

    assign MMCM_RST = mmcm_rst_q;
    assign RST_OUT  = rst_out_q;
    assign READY    = ready_q;
    assign FAULT    = fault_q;
    assign RETRIES  = retries_q;

endmodule

// File: doc/mmcm_lock_supervisor.md
# mmcm_lock_supervisor

Parametrised lock supervisor and reset sequencer for an MMCM clock generator. It runs in the MMCM input-clock domain and drives the MMCM `RST`. It watches the asynchronous `LOCKED` output and retries failed locks with a bounded retry count. Once lock has been stable for a set time, it releases a configurable number of downstream reset channels in a staggered order. It sits between the MMCM primitive wrapper and the per-domain reset synchronisers of the video and game logic.

## Interface
- `RST_CYCLES`, 16: cycles `MMCM_RST` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 100000: cycles allowed in WAIT_LOCK before the attempt fails (≥1).
- `STABLE_CYCLES`, 1024: consecutive synchronised-lock cycles required before release (≥1).
- `MAX_RETRIES`, 3: failed attempts tolerated before FAULT; total attempts = MAX_RETRIES+1.
- `NUM_OUT`, 2: number of reset channels (≥1).
- `STAGGER`, 8: cycles between successive channel releases (≥1).
- `CLKIN` in 1: MMCM reference clock; the only clock.
- `RSTN` in 1: asynchronous, active-low reset.
- `MMCM_LOCKED` in 1: MMCM `LOCKED`, asynchronous to `CLKIN`. Passes through a 2-flop synchroniser; `lock_s` is the second flop.
- `RELOCK_REQ` in 1: single-cycle request to restart the MMCM, e.g. after a DRP reconfiguration.
- `MMCM_RST` out 1: drives the MMCM `RST`.
- `RST_OUT` out NUM_OUT: active-high resets, one per downstream domain. Consumers synchronise them locally.
- `READY` out 1: high in RUN.
- `FAULT` out 1: sticky lock failure.
- `RETRIES` out clog2(MAX_RETRIES+1): failed attempts since the last RUN entry or clear.

## Operation
- Reset values (RSTN low, asynchronous):
  - state = HOLD, `MMCM_RST`=1, `RST_OUT`=all 1, `READY`=0, `FAULT`=0, `RETRIES`=0.
  - Counter = 0 and synchroniser flops = 0.
- HOLD:
  - `MMCM_RST`=1 and all `RST_OUT`=1.
  - Stays exactly RST_CYCLES cycles, then goes to WAIT_LOCK with the counter cleared.
- WAIT_LOCK:
  - `MMCM_RST`=0.
  - `lock_s`=1 → SETTLE.
  - Counter reaches LOCK_TIMEOUT−1 with `lock_s`=0 (timeout):
    - If `RETRIES`==MAX_RETRIES → FAULT.
    - Otherwise `RETRIES`++ → HOLD.
- SETTLE:
  - `lock_s`=0 → WAIT_LOCK. The counter restarts, `RETRIES` is unchanged and `MMCM_RST` stays 0.
  - STABLE_CYCLES consecutive cycles with `lock_s`=1 → RELEASE.
- RELEASE:
  - `RST_OUT[i]` clears at RELEASE cycle i·STAGGER (cycle 0 = first cycle in RELEASE). Release order is index 0 first.
  - After `RST_OUT[NUM_OUT−1]` clears → RUN.
- RUN:
  - `READY`=1 and `RETRIES` cleared on entry.
- Lock loss (`lock_s`=0) in RELEASE or RUN → HOLD.
  - All `RST_OUT`=1 and `READY`=0 on the next edge.
  - `RETRIES` is not incremented.
- FAULT:
  - `FAULT`=1, `MMCM_RST`=1, all `RST_OUT`=1, `READY`=0.
  - `MMCM_LOCKED` is ignored.
  - Exit only via RSTN or RELOCK_REQ.
- RELOCK_REQ (any state):
  - Next state HOLD; `RETRIES`=0, `FAULT`=0, all `RST_OUT`=1, `READY`=0.
  - Highest priority, over timeout and lock loss in the same cycle.
- Counter width: clog2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, (NUM_OUT−1)·STAGGER+1))+1. It never wraps; it is cleared on every state change.
- All outputs are registered. No output depends combinationally on an input.

## Timing
- `MMCM_LOCKED` to `lock_s`: 2 cycles.
- `lock_s` rise to RELEASE entry: STABLE_CYCLES cycles.
- RELEASE entry to `READY`=1: (NUM_OUT−1)·STAGGER+1 cycles.
- `lock_s` fall in RELEASE/RUN to all `RST_OUT` high: 1 cycle, i.e. 3 cycles from the `MMCM_LOCKED` pin.
- After RSTN deasserts, `MMCM_RST` stays high for exactly RST_CYCLES rising edges.
- Each failed attempt takes RST_CYCLES+LOCK_TIMEOUT cycles.
- RSTN asserted mid-RELEASE or mid-RUN: all outputs return to reset values without waiting for a clock edge.

## Test plan
Parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, NUM_OUT=3, STAGGER=2.

1. **Nominal:** RSTN rises; `MMCM_LOCKED` goes high 6 cycles later → `MMCM_RST` high 4 edges. `RST_OUT[0,1,2]` clear at 0, 2 and 4 cycles into RELEASE; `READY`=1 one cycle later; `RETRIES`=0.
2. **Never locks:** `MMCM_LOCKED` held 0 → three 4-cycle `MMCM_RST` pulses with 20-cycle gaps. `RETRIES` steps 1, 2. After the third timeout, `FAULT`=1 and `MMCM_RST` is held high with `RETRIES`=2.
3. **Glitch in SETTLE:** `MMCM_LOCKED` low for 1 cycle at SETTLE cycle 5 → back to WAIT_LOCK. `MMCM_RST` stays 0, `RETRIES` unchanged, and release comes 8 cycles after `lock_s` returns.
4. **Lock loss in RUN:** drop `MMCM_LOCKED` → 3 cycles later all `RST_OUT`=1 and `READY`=0. `MMCM_RST` is high for 4 cycles, and the full sequence repeats once lock returns.
5. **Relock:** RELOCK_REQ in FAULT, and separately RELOCK_REQ coinciding with a WAIT_LOCK timeout → both go to HOLD with `FAULT`=0 and `RETRIES`=0.
6. **Async reset:** RSTN low between clock edges during RELEASE, with `RST_OUT[0]` already cleared → all outputs return to reset values before the next clock edge.
